// File: rtl/led_scan_mux.sv
// Scans eight active-low 7-segment digits onto one shared bus with ghost blanking, brightness and per-digit enables.
// Optional decimal-point path enabled by defining SCAN_DP_EN. All outputs are registered.
module led_scan_mux #(
   parameter int SCAN_DIV  = 16,
   parameter int BLANK_CYC = 2,
   parameter int CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [55:0] seg_in,
   input  logic [7:0]  digit_en,
   input  logic [2:0]  brightness,
   output logic [0:6]  seg_out,
   output logic [7:0]  an,
   output logic        frame_start
`ifdef SCAN_DP_EN
   ,
   input  logic [7:0]  dp_in,
   output logic        dp_out
`endif
);

   localparam int LW = CNT_W + 3;
   localparam logic [LW-1:0]    ACT_LEN = LW'(SCAN_DIV - BLANK_CYC);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] SNAP    = CNT_W'(BLANK_CYC - 1);

   typedef enum logic [1:0] {BLANK, LIT, OFF} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] slot_cnt;
   logic [2:0]       digit_idx;
   logic [2:0]       b_lat;
   logic [6:0]       seg_lat;
   logic [2:0]       b_eff;
   logic [LW-1:0]    lit_len, lit_end, cnt_ext;
   logic             slot_last, lit_on, fs_nxt;
   logic [7:0]       an_nxt;
   logic [6:0]       seg_nxt;
`ifdef SCAN_DP_EN
   logic             dp_lat, dp_nxt;
`endif

   always_comb begin
      // brightness is latched on slot cycle 0, so use the live input in that cycle
      b_eff     = (slot_cnt == '0) ? brightness : b_lat;
      lit_len   = (ACT_LEN * (LW'(b_eff) + LW'(1))) >> 3;
      lit_end   = LW'(BLANK_CYC) + lit_len;
      cnt_ext   = LW'(slot_cnt) + LW'(1);
      slot_last = (slot_cnt == LAST);

      state_nxt = state;
      case (state)
         BLANK:   if (slot_cnt == SNAP) state_nxt = (lit_len != '0) ? LIT : OFF;
         LIT:     if (cnt_ext == lit_end) state_nxt = slot_last ? BLANK : OFF;
         OFF:     if (slot_last) state_nxt = BLANK;
         default: state_nxt = BLANK;
      endcase

      lit_on  = (state == LIT) && digit_en[digit_idx];
      an_nxt  = lit_on ? ~(8'h01 << digit_idx) : 8'hFF;
      seg_nxt = lit_on ? seg_lat : 7'h7F;
      fs_nxt  = (slot_cnt == '0) && (digit_idx == 3'd0);
`ifdef SCAN_DP_EN
      dp_nxt  = lit_on ? dp_lat : 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt    <= '0;
         digit_idx   <= 3'd0;
         b_lat       <= 3'd0;
         seg_lat     <= 7'h7F;
         state       <= BLANK;
         an          <= 8'hFF;
         seg_out     <= 7'h7F;
         frame_start <= 1'b0;
`ifdef SCAN_DP_EN
         dp_lat      <= 1'b1;
         dp_out      <= 1'b1;
`endif
      end else begin
         slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
         if (slot_last) digit_idx <= digit_idx + 3'd1;
         if (slot_cnt == '0) b_lat <= brightness;
         // snapshot on the last blank cycle so the lit window sees a stable pattern
         if (slot_cnt == SNAP) begin
            seg_lat <= seg_in[7*digit_idx +: 7];
`ifdef SCAN_DP_EN
            dp_lat  <= dp_in[digit_idx];
`endif
         end
         state       <= state_nxt;
         an          <= an_nxt;
         seg_out     <= seg_nxt;
         frame_start <= fs_nxt;
`ifdef SCAN_DP_EN
         dp_out      <= dp_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_led_scan_mux.sv
// Directed bench for led_scan_mux with a per-cycle expected-output scoreboard.
module tb_led_scan_mux;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [55:0] seg_in;
   logic [7:0]  digit_en;
   logic [2:0]  brightness;
   logic [0:6]  seg_out;
   logic [7:0]  an;
   logic        frame_start;
`ifdef SCAN_DP_EN
   logic [7:0]  dp_in = 8'hFF;
   logic        dp_out;
`endif

   always #5 clk = ~clk;

   led_scan_mux #(.SCAN_DIV(16), .BLANK_CYC(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .digit_en(digit_en),
      .brightness(brightness), .seg_out(seg_out), .an(an),
      .frame_start(frame_start)
`ifdef SCAN_DP_EN
      , .dp_in(dp_in), .dp_out(dp_out)
`endif
   );

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       fs;
   } exp_t;

   exp_t       sb[$];
   int         tests = 0;
   int         fails = 0;
   int         m_cnt = 0;
   logic [2:0] m_b = 3'd0;
   logic [6:0] m_seg = 7'h7F;
   int         fs_seen = 0;
   int         an2_low = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s cycle=%0d got=%h exp=%h", tag, m_cnt, got, exp);
      end
   endtask

   // Expected outputs follow from the cycle index since reset release:
   // slot = n%16, digit = (n/16)%8, lit window = slot cycles 2 .. 2+lit-1.
   task automatic tick();
      exp_t e, g;
      int   s, d, lit;
      if (rst) begin
         e.an = 8'hFF; e.seg = 7'h7F; e.fs = 1'b0;
         m_cnt = 0;
      end else begin
         s = m_cnt % 16;
         d = (m_cnt / 16) % 8;
         if (s == 0) m_b = brightness;
         if (s == 1) m_seg = seg_in[7*d +: 7];
         lit  = (14 * (int'(m_b) + 1)) / 8;
         e.fs = (m_cnt % 128 == 0);
         if (s >= 2 && s < 2 + lit && digit_en[d]) begin
            e.an  = ~(8'h01 << d);
            e.seg = m_seg;
         end else begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
         end
         m_cnt++;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("an", an, g.an);
      chk("seg_out", {1'b0, seg_out}, {1'b0, g.seg});
      chk("frame_start", {7'b0, frame_start}, {7'b0, g.fs});
      chk("one_anode", {7'b0, ($countones(~an) <= 1)}, 8'h01);
      if (frame_start) fs_seen++;
      if (!an[2]) an2_low++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Advance until the next cycle to be clocked is frame position pos.
   task automatic run_to(input int pos);
      int k;
      k = 0;
      while ((m_cnt % 128) != pos && k < 200) begin
         tick();
         k++;
      end
      chk("run_to_bound", {7'b0, (k < 200)}, 8'h01);
   endtask

   initial begin
      seg_in     = {7'h12, 7'h24, 7'h00, 7'h4C, 7'h01, 7'h06, 7'h4F, 7'h01};
      seg_in[21 +: 7] = 7'b0000001;
      digit_en   = 8'hFF;
      brightness = 3'd7;

      run(3);
      chk("reset_an", an, 8'hFF);
      chk("reset_seg", {1'b0, seg_out}, 8'h7F);

      rst = 1'b0;
      fs_seen = 0;
      run(130);
      chk("fs_two_frames", 8'(fs_seen), 8'd2);

      brightness = 3'd3;
      run(256);
      brightness = 3'd0;
      run(256);
      brightness = 3'd7;
      run(128);

      // digit 3 pattern changes mid-slot; the latched value must hold
      run_to(3*16 + 5);
      seg_in[21 +: 7] = 7'b1001111;
      for (int i = 0; i < 11; i++) begin
         tick();
         if (an == 8'hF7) chk("seg_hold", {1'b0, seg_out}, 8'h01);
      end
      run_to(3*16 + 3);
      chk("seg_next_an", an, 8'hF7);
      chk("seg_next", {1'b0, seg_out}, {1'b0, 7'b1001111});

      digit_en = 8'b11111011;
      run_to(0);
      fs_seen = 0;
      an2_low = 0;
      run(128);
      chk("an2_never", 8'(an2_low), 8'd0);
      chk("fs_one_frame", 8'(fs_seen), 8'd1);
      digit_en = 8'hFF;

      run_to(1*16 + 6);
      digit_en[1] = 1'b0;
      run(4);
      digit_en[1] = 1'b1;
      run(10);

      run_to(5*16 + 6);
      rst = 1'b1;
      tick();
      chk("rst_mid_an", an, 8'hFF);
      chk("rst_mid_seg", {1'b0, seg_out}, 8'h7F);
      rst = 1'b0;
      tick();
      chk("restart_fs", {7'b0, frame_start}, 8'h01);
      run(40);

      for (int i = 0; i < 1280; i++) begin
         if (i % 7 == 0) begin
            seg_in     = 56'({$urandom(), $urandom()});
            brightness = 3'($urandom_range(0, 7));
            digit_en   = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'hFF;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
